// File: rtl/vga_pkg.sv
// Shared VGA pixel-stream types and widths for the sprite drawing stages.
package vga_pkg;
   localparam int HCOUNT_W = 11;
   localparam int RGB_W    = 12;
   localparam int ADDR_X_W = 6;
   localparam int ADDR_Y_W = 6;

   typedef struct packed {
      logic [HCOUNT_W-1:0] hcount;
      logic [HCOUNT_W-1:0] vcount;
      logic                hsync;
      logic                vsync;
      logic                hblnk;
      logic                vblnk;
      logic [RGB_W-1:0]    rgb;
   } vga_if_t;
endpackage

// File: rtl/delay_line.sv
// Fixed-depth register pipeline; synchronous reset clears every stage.
module delay_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [DEPTH-1:0][WIDTH-1:0] stage_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q <= '0;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/draw_tank.sv
// Tank sprite overlay: generates the sprite ROM address, keys out transparent
// ROM pixels and re-emits VGA timing aligned with the composed pixel (3 clk latency).
module draw_tank
   import vga_pkg::*;
#(
   parameter int         SPRITE_W  = 48,
   parameter int         SPRITE_H  = 64,
   parameter logic [11:0] KEY_COLOR = 12'h0F0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic [10:0] xpos,
   input  logic [10:0] ypos,
   output logic [11:0] pixel_addr,
   input  logic [11:0] rgb_pixel,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);
   vga_if_t bus_in;
   assign bus_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                     vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

   logic [HCOUNT_W-1:0] xlat_q, ylat_q;
   logic                vblnk_prev_q;

   // Position only moves at the vblnk rising edge so a frame never tears.
   always_ff @(posedge clk) begin
      if (rst) begin
         xlat_q       <= '0;
         ylat_q       <= '0;
         vblnk_prev_q <= 1'b0;
      end else begin
         vblnk_prev_q <= bus_in.vblnk;
         if (bus_in.vblnk && !vblnk_prev_q) begin
            xlat_q <= xpos;
            ylat_q <= ypos;
         end
      end
   end

   // Sprite extents at 12 bits so a position near 2047 does not wrap.
   logic [HCOUNT_W:0] x_end, y_end;
   logic              hit;
   logic [ADDR_X_W-1:0] addr_x;
   logic [ADDR_Y_W-1:0] addr_y;

   assign x_end  = {1'b0, xlat_q} + 12'(SPRITE_W);
   assign y_end  = {1'b0, ylat_q} + 12'(SPRITE_H);
   assign hit    = (bus_in.hcount >= xlat_q) && ({1'b0, bus_in.hcount} < x_end) &&
                   (bus_in.vcount >= ylat_q) && ({1'b0, bus_in.vcount} < y_end);
   assign addr_x = bus_in.hcount[ADDR_X_W-1:0] - xlat_q[ADDR_X_W-1:0];
   assign addr_y = bus_in.vcount[ADDR_Y_W-1:0] - ylat_q[ADDR_Y_W-1:0];

   logic [11:0] pixel_addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pixel_addr_q <= '0;
      end else begin
         pixel_addr_q <= hit ? {addr_y, addr_x} : 12'h000;
      end
   end

   assign pixel_addr = pixel_addr_q;

   localparam int TIM_W = 2*HCOUNT_W + 4;
   logic [TIM_W-1:0] tim_d, tim_q;

   assign tim_d = {bus_in.hcount, bus_in.vcount, bus_in.hsync, bus_in.vsync,
                   bus_in.hblnk, bus_in.vblnk};

   delay_line #(.WIDTH(TIM_W), .DEPTH(3)) u_tim_dly (
      .clk (clk),
      .rst (rst),
      .d_i (tim_d),
      .q_o (tim_q)
   );

   // Compose-side copy only needs to reach stage 2, where rgb_pixel arrives.
   localparam int PIX_W = RGB_W + 3;
   logic [PIX_W-1:0] pix_d, pix_q;
   logic             hit_s2, hblnk_s2, vblnk_s2;
   logic [RGB_W-1:0] rgb_s2;

   assign pix_d = {hit, bus_in.hblnk, bus_in.vblnk, bus_in.rgb};

   delay_line #(.WIDTH(PIX_W), .DEPTH(2)) u_pix_dly (
      .clk (clk),
      .rst (rst),
      .d_i (pix_d),
      .q_o (pix_q)
   );

   assign {hit_s2, hblnk_s2, vblnk_s2, rgb_s2} = pix_q;

   logic [RGB_W-1:0] rgb_out_d, rgb_out_q;

   always_comb begin
      rgb_out_d = rgb_s2;
      if (hblnk_s2 || vblnk_s2) begin
         rgb_out_d = '0;
      end else if (hit_s2 && (rgb_pixel != KEY_COLOR)) begin
         rgb_out_d = rgb_pixel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_out_q <= '0;
      end else begin
         rgb_out_q <= rgb_out_d;
      end
   end

   assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim_q;
   assign rgb_out = rgb_out_q;
endmodule
